uart_bridge_datapath: RTL and testbench
=======================================

// Module: uart_bridge_datapath
// PURPOSE
// - Byte-serial to word datapath for the UART-to-bus bridge; the bridge FSM drives every control input.
// - Assembles 4 received UART bytes into a 32-bit address word and a 32-bit write-data word.
// - Captures a 32-bit bus read word and serialises it back out as bytes for UART TX.
// - Built from one byte counter (count_reg), per-byte enabled registers (d_reg) and a 4:1 byte mux (mux_4to1).
// PARAMETERS
// - BUS_WIDTH  32  bus word width; fixed at 4 bytes (BUS_WIDTH/8 == 4 required).
// - CNT_WIDTH  3   byte counter width; must be wide enough to hold the value 4.
// PORTS
// - clk          in   1          single clock; all state changes on its rising edge.
// - rst          in   1          synchronous, active-high reset.
// - rx_byte      in   8          received UART byte.
// - rx_valid     in   1          rx_byte is valid this cycle (1-cycle pulse).
// - cnt_en       in   1          increment byte counter.
// - cnt_clr      in   1          clear byte counter to 0.
// - addr_load    in   1          route rx bytes into the address register.
// - data_load    in   1          route rx bytes into the write-data register.
// - word_clr     in   1          clear addr and wdata registers.
// - bus_in       in   BUS_WIDTH  bus read data.
// - rdata_cap    in   1          capture bus_in into rdata.
// - rdata_clr    in   1          clear rdata.
// - out_sel_addr in   1          bus_out select: 1 = addr, 0 = wdata.
// - bus_out      out  BUS_WIDTH  combinational mux of addr / wdata.
// - tx_byte      out  8          rdata byte selected by byte_count[1:0].
// - byte_count   out  CNT_WIDTH  current counter value.
// - addr         out  BUS_WIDTH  assembled address word.
// - wdata        out  BUS_WIDTH  assembled write-data word.
// - rdata        out  BUS_WIDTH  captured read word.
// - debug_out    out  8          see CONFIGURATION.
// BEHAVIOUR
// - Reset: byte_count, addr, wdata and rdata are all 0. rst takes priority over every other input.
// - Counter:
//   - Priority is rst > cnt_clr > cnt_en.
//   - Increments by 1 per enabled cycle.
//   - Wraps modulo 2^CNT_WIDTH (7 -> 0).
// - Byte load:
//   - When rx_valid, addr_load and byte_count < 4: addr byte lane byte_count[1:0] <= rx_byte.
//     - Lane 0 = bits [7:0], so bytes are little-endian (first byte received is the LSB).
//   - data_load does the same into wdata.
//   - If addr_load and data_load are both high, both registers load.
//   - When byte_count >= 4, no load occurs.
//   - Non-selected lanes hold their value.
//   - word_clr zeroes addr and wdata. word_clr beats a load in the same cycle.
// - The counter does not auto-increment on a load; the FSM asserts cnt_en together with rx_valid.
//   - A load uses the pre-increment count value.
// - rdata:
//   - rdata_clr beats rdata_cap.
//   - rdata_cap loads the full word on the next edge (1-cycle latency).
// - tx_byte = rdata[8*byte_count[1:0] +: 8], purely combinational, no offset.
//   - count 0 -> [7:0], count 3 -> [31:24]; count 4 aliases lane 0.
// - bus_out = out_sel_addr ? addr : wdata, combinational.
// CONFIGURATION
// - BRIDGE_DEBUG_EN defined: debug_out = rdata[7:0].
// - BRIDGE_DEBUG_EN undefined: debug_out is tied to 8'h00 and no extra logic is generated.
// TESTING
// - Reset: assert rst for 1 cycle -> byte_count=0, addr=wdata=rdata=0, tx_byte=0.
// - Address load:
//   - Stimulus: addr_load=1, rx bytes 0x78,0x56,0x34,0x12, each with rx_valid=1 and cnt_en=1.
//   - Response: addr=0x12345678 and byte_count=4.
//   - Then a 5th byte 0xFF -> addr unchanged.
// - Write data and mux:
//   - Stimulus: data_load bytes 0xEF,0xBE,0xAD,0xDE.
//   - Response: wdata=0xDEADBEEF; bus_out=wdata with out_sel_addr=0, =addr with out_sel_addr=1.
// - TX serialise:
//   - Stimulus: bus_in=0xA1B2C3D4 with rdata_cap=1, then cnt_clr, then step cnt_en.
//   - Response: tx_byte = D4, C3, B2, A1 at counts 0..3.
// - Priority:
//   - cnt_clr and cnt_en asserted together -> count=0.
//   - rst during a load -> all registers 0.
//   - Counter at 7 with cnt_en -> 0.
//   - rdata_clr and rdata_cap together -> rdata=0.
// - Debug: with BRIDGE_DEBUG_EN, debug_out=0xD4 after the capture above; without it, debug_out=0x00.

Source files
------------

// File: rtl/uart_bridge_datapath.sv
// rtl/uart_bridge_datapath.sv - byte-serial to word datapath for the UART-to-bus bridge
//
// Purpose: assembles received UART bytes into 32-bit address and write-data
// words, and captures a bus read word that is sent back out one byte at a time.
// Every control input comes from the bridge FSM.
// Optional feature macro: BRIDGE_DEBUG_EN (drives debug_out = rdata[7:0]).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rx_byte, rx_valid          received byte and its 1-cycle strobe
//   cnt_en, cnt_clr            byte counter increment / clear
//   addr_load, data_load       steer rx bytes into addr / wdata
//   word_clr                   zero addr and wdata
//   bus_in, rdata_cap, rdata_clr  bus read word capture / clear
//   out_sel_addr               bus_out select (1 = addr, 0 = wdata)
//   bus_out, tx_byte           combinational word and byte outputs
//   byte_count, addr, wdata, rdata  register state
//   debug_out                  debug byte (0 unless BRIDGE_DEBUG_EN)

module count_reg #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + WIDTH'(1);   // wraps naturally at 2^WIDTH
  end
endmodule

module d_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;   // clear beats load
    else if (en)  q <= d;
  end
endmodule

module mux_4to1 #(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] out
);
  always_comb begin
    out = in0;
    case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end
endmodule

module uart_bridge_datapath #(
  parameter int BUS_WIDTH = 32,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  input  logic                 cnt_en,
  input  logic                 cnt_clr,
  input  logic                 addr_load,
  input  logic                 data_load,
  input  logic                 word_clr,
  input  logic [BUS_WIDTH-1:0] bus_in,
  input  logic                 rdata_cap,
  input  logic                 rdata_clr,
  input  logic                 out_sel_addr,
  output logic [BUS_WIDTH-1:0] bus_out,
  output logic [7:0]           tx_byte,
  output logic [CNT_WIDTH-1:0] byte_count,
  output logic [BUS_WIDTH-1:0] addr,
  output logic [BUS_WIDTH-1:0] wdata,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic [7:0]           debug_out
);
  localparam int N_LANES = BUS_WIDTH / 8;

  // Loads only happen while the counter still points at a real lane; the
  // FSM increments the counter in the same cycle, so the load sees the
  // pre-increment value.
  logic lane_ok;
  assign lane_ok = rx_valid && (byte_count < CNT_WIDTH'(N_LANES));

  count_reg #(.WIDTH(CNT_WIDTH)) u_count (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .q   (byte_count)
  );

  // One enabled register per byte lane; lane 0 is the first byte received.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic lane_hit;
    assign lane_hit = lane_ok && (byte_count[1:0] == 2'(i));

    d_reg #(.WIDTH(8)) u_addr_lane (
      .clk (clk),
      .rst (rst),
      .clr (word_clr),
      .en  (lane_hit && addr_load),
      .d   (rx_byte),
      .q   (addr[8*i +: 8])
    );

    d_reg #(.WIDTH(8)) u_wdata_lane (
      .clk (clk),
      .rst (rst),
      .clr (word_clr),
      .en  (lane_hit && data_load),
      .d   (rx_byte),
      .q   (wdata[8*i +: 8])
    );
  end

  d_reg #(.WIDTH(BUS_WIDTH)) u_rdata (
    .clk (clk),
    .rst (rst),
    .clr (rdata_clr),
    .en  (rdata_cap),
    .d   (bus_in),
    .q   (rdata)
  );

  // Only the low two counter bits select, so count 4 aliases lane 0.
  mux_4to1 #(.WIDTH(8)) u_tx_mux (
    .sel (byte_count[1:0]),
    .in0 (rdata[7:0]),
    .in1 (rdata[15:8]),
    .in2 (rdata[23:16]),
    .in3 (rdata[31:24]),
    .out (tx_byte)
  );

  assign bus_out = out_sel_addr ? addr : wdata;

`ifdef BRIDGE_DEBUG_EN
  assign debug_out = rdata[7:0];
`else
  assign debug_out = 8'h00;
`endif

endmodule

// File: tb/tb_uart_bridge_datapath.sv
// tb/tb_uart_bridge_datapath.sv - directed scoreboard bench for uart_bridge_datapath

module tb_uart_bridge_datapath;
  logic        clk50MHz = 1'b0;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid, cnt_en, cnt_clr, addr_load, data_load, word_clr;
  logic [31:0] bus_in;
  logic        rdata_cap, rdata_clr, out_sel_addr;
  logic [31:0] bus_out, addr, wdata, rdata;
  logic [7:0]  tx_byte, debug_out;
  logic [2:0]  byte_count;

  always #10 clk50MHz = ~clk50MHz;

  uart_bridge_datapath dut (
    .clk          (clk50MHz),
    .rst          (rst),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .cnt_en       (cnt_en),
    .cnt_clr      (cnt_clr),
    .addr_load    (addr_load),
    .data_load    (data_load),
    .word_clr     (word_clr),
    .bus_in       (bus_in),
    .rdata_cap    (rdata_cap),
    .rdata_clr    (rdata_clr),
    .out_sel_addr (out_sel_addr),
    .bus_out      (bus_out),
    .tx_byte      (tx_byte),
    .byte_count   (byte_count),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .debug_out    (debug_out)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_val(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_item_t it;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
      end
    end
  endtask

  // Drive happens before the call; sampling is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk50MHz);
    #1;
  endtask

  task automatic idle();
    rx_byte = 8'h00; rx_valid = 0; cnt_en = 0; cnt_clr = 0;
    addr_load = 0; data_load = 0; word_clr = 0;
    rdata_cap = 0; rdata_clr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; rx_valid = 1; cnt_en = 1;
    tick();
    rx_valid = 0; cnt_en = 0;
  endtask

  initial begin
    logic [7:0] abytes [4];
    logic [7:0] dbytes [4];
    logic [7:0] txexp  [5];
    abytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    dbytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    txexp  = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hD4};

    idle();
    bus_in = 32'h0; out_sel_addr = 0;
    rst = 1;
    tick();
    rst = 0;
    expect_val("reset_count", 32'd0);  check(32'(byte_count));
    expect_val("reset_addr",  32'h0);  check(addr);
    expect_val("reset_wdata", 32'h0);  check(wdata);
    expect_val("reset_rdata", 32'h0);  check(rdata);
    expect_val("reset_tx",    32'h0);  check(32'(tx_byte));

    // Address assembly, little-endian.
    addr_load = 1;
    for (int i = 0; i < 4; i++) send_byte(abytes[i]);
    expect_val("addr_word",  32'h12345678); check(addr);
    expect_val("addr_count", 32'd4);        check(32'(byte_count));
    send_byte(8'hFF);
    expect_val("addr_5th_byte_ignored", 32'h12345678); check(addr);
    addr_load = 0;
    cnt_clr = 1; tick(); cnt_clr = 0;

    // Write-data assembly and output mux.
    data_load = 1;
    for (int i = 0; i < 4; i++) send_byte(dbytes[i]);
    data_load = 0;
    expect_val("wdata_word", 32'hDEADBEEF); check(wdata);
    expect_val("addr_untouched", 32'h12345678); check(addr);
    out_sel_addr = 0; #1;
    expect_val("bus_out_wdata", 32'hDEADBEEF); check(bus_out);
    out_sel_addr = 1; #1;
    expect_val("bus_out_addr", 32'h12345678); check(bus_out);

    // Both loads together hit lane 0 of both words.
    cnt_clr = 1; tick(); cnt_clr = 0;
    addr_load = 1; data_load = 1;
    send_byte(8'h99);
    addr_load = 0; data_load = 0;
    expect_val("dual_load_addr",  32'h12345699); check(addr);
    expect_val("dual_load_wdata", 32'hDEADBE99); check(wdata);

    // word_clr beats a load.
    addr_load = 1; data_load = 1; word_clr = 1;
    send_byte(8'h42);
    addr_load = 0; data_load = 0; word_clr = 0;
    expect_val("word_clr_addr",  32'h0); check(addr);
    expect_val("word_clr_wdata", 32'h0); check(wdata);

    // Read capture and byte serialisation.
    bus_in = 32'hA1B2C3D4; rdata_cap = 1;
    tick();
    rdata_cap = 0; bus_in = 32'h0;
    expect_val("rdata_cap", 32'hA1B2C3D4); check(rdata);
`ifdef BRIDGE_DEBUG_EN
    expect_val("debug_out", 32'hD4);
`else
    expect_val("debug_out", 32'h00);
`endif
    check(32'(debug_out));
    cnt_clr = 1; tick(); cnt_clr = 0;
    for (int i = 0; i < 5; i++) begin
      expect_val($sformatf("tx_byte_cnt%0d", i), 32'(txexp[i]));
      check(32'(tx_byte));
      cnt_en = 1; tick(); cnt_en = 0;
    end

    // cnt_clr beats cnt_en.
    cnt_clr = 1; cnt_en = 1; tick(); cnt_clr = 0; cnt_en = 0;
    expect_val("clr_beats_en", 32'd0); check(32'(byte_count));

    // Counter wraps 7 -> 0.
    cnt_en = 1;
    for (int i = 0; i < 7; i++) tick();
    cnt_en = 0;
    expect_val("count_at_7", 32'd7); check(32'(byte_count));
    cnt_en = 1; tick(); cnt_en = 0;
    expect_val("count_wrap", 32'd0); check(32'(byte_count));

    // rdata_clr beats rdata_cap.
    bus_in = 32'h55AA55AA; rdata_cap = 1; rdata_clr = 1;
    tick();
    rdata_cap = 0; rdata_clr = 0;
    expect_val("rdata_clr_beats_cap", 32'h0); check(rdata);

    // Reset during a load clears everything.
    rdata_cap = 1; tick(); rdata_cap = 0;
    addr_load = 1; send_byte(8'h5A); addr_load = 0;
    expect_val("pre_rst_addr", 32'h0000005A); check(addr);
    rst = 1; addr_load = 1; data_load = 1; rdata_cap = 1;
    send_byte(8'hC5);
    rst = 0; idle();
    expect_val("rst_load_addr",  32'h0); check(addr);
    expect_val("rst_load_wdata", 32'h0); check(wdata);
    expect_val("rst_load_rdata", 32'h0); check(rdata);
    expect_val("rst_load_count", 32'd0); check(32'(byte_count));

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
